// File: rtl/s10077_sensor_emu.sv
// s10077_sensor_emu: linear image sensor emulator.
// SENSOR_CLK and ST arrive asynchronously. Both are resynchronised into the
// FPGA_CLK domain. All sequencing advances only on detected SENSOR_CLK rises.
// A frame runs: ST high integrates, ST low starts a fixed start delay, then
// NPIX pixels are read with one EOC pulse each, then one EOS pulse.
// Handshake note: EOC/EOS are free-running strobes with no back-pressure.
// EOC is high for one SENSOR_CLK period per pixel, and PIX_IDX/PIX_DATA are
// valid from its rise until the next EOC.
module s10077_sensor_emu #(
  parameter int NPIX      = 1024,
  parameter int START_DLY = 48,
  parameter int PIX_CLKS  = 4
) (
  input  logic        FPGA_CLK,
  input  logic        FPGA_RST,
  input  logic        SENSOR_CLK,
  input  logic        ST,
  output logic        EOC,
  output logic        EOS,
  output logic [10:0] PIX_IDX,
  output logic [11:0] PIX_DATA,
  output logic [23:0] INT_CNT,
  output logic [15:0] FRAME_CNT,
  output logic        BUSY,
  output logic        OVERRUN,
  output logic [2:0]  dbg_state
);

  localparam int DW = (START_DLY > 1) ? $clog2(START_DLY) : 1;
  localparam int PW = $clog2(PIX_CLKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INTEG = 3'd1,
    S_DELAY = 3'd2,
    S_READ  = 3'd3,
    S_EOSP  = 3'd4
  } state_t;

  logic [2:0]    sclk_sync_q;
  logic [1:0]    st_sync_q;
  logic          sclk_rise;
  logic          st_sync;

  state_t        state_q, state_d;
  logic [23:0]   int_cnt_q, int_cnt_d;
  logic [DW-1:0] dly_cnt_q, dly_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [10:0]   pix_idx_q, pix_idx_d;
  logic [11:0]   pix_data_q, pix_data_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          eoc_q, eoc_d;
  logic          eos_q, eos_d;
  logic          overrun_q, overrun_d;

  // Two-flop synchronisers, plus a third SENSOR_CLK stage for edge detection
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      sclk_sync_q <= '0;
      st_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], SENSOR_CLK};
      st_sync_q   <= {st_sync_q[0], ST};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign st_sync   = st_sync_q[1];

  // Frame sequencer: next state and outputs, evaluated only on SENSOR_CLK rises
  always_comb begin
    state_d     = state_q;
    int_cnt_d   = int_cnt_q;
    dly_cnt_d   = dly_cnt_q;
    phase_d     = phase_q;
    pix_idx_d   = pix_idx_q;
    pix_data_d  = pix_data_q;
    frame_cnt_d = frame_cnt_q;
    eoc_d       = eoc_q;
    eos_d       = eos_q;
    overrun_d   = overrun_q;
    if (sclk_rise) begin
      // A new start while a readout is in flight is flagged but ignored
      if (st_sync && (state_q == S_DELAY || state_q == S_READ || state_q == S_EOSP))
        overrun_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (st_sync) begin
            state_d   = S_INTEG;
            int_cnt_d = 24'd1;
          end
        end
        S_INTEG: begin
          if (st_sync) begin
            if (int_cnt_q != 24'hFF_FFFF) int_cnt_d = int_cnt_q + 24'd1;
          end else begin
            state_d   = S_DELAY;
            dly_cnt_d = '0;
          end
        end
        S_DELAY: begin
          if (dly_cnt_q == DW'(START_DLY - 1)) begin
            state_d    = S_READ;
            pix_idx_d  = '0;
            phase_d    = '0;
            eoc_d      = 1'b1;
            pix_data_d = frame_cnt_q[11:0];
          end else begin
            dly_cnt_d = dly_cnt_q + DW'(1);
          end
        end
        S_READ: begin
          if (phase_q == PW'(PIX_CLKS - 1)) begin
            if (pix_idx_q != 11'(NPIX - 1)) begin
              pix_idx_d  = pix_idx_q + 11'd1;
              phase_d    = '0;
              eoc_d      = 1'b1;
              pix_data_d = {1'b0, pix_idx_q + 11'd1} + frame_cnt_q[11:0];
            end else begin
              state_d = S_EOSP;
              eos_d   = 1'b1;
            end
          end else begin
            // Phase 0 also drops EOC so it lasts exactly one SENSOR_CLK period
            if (phase_q == '0) eoc_d = 1'b0;
            phase_d = phase_q + PW'(1);
          end
        end
        S_EOSP: begin
          eos_d       = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Sequencer registers; reset aborts any frame in flight without an EOS
  always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
    if (FPGA_RST) begin
      state_q     <= S_IDLE;
      int_cnt_q   <= '0;
      dly_cnt_q   <= '0;
      phase_q     <= '0;
      pix_idx_q   <= '0;
      pix_data_q  <= '0;
      frame_cnt_q <= '0;
      eoc_q       <= 1'b0;
      eos_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_cnt_q   <= int_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
      phase_q     <= phase_d;
      pix_idx_q   <= pix_idx_d;
      pix_data_q  <= pix_data_d;
      frame_cnt_q <= frame_cnt_d;
      eoc_q       <= eoc_d;
      eos_q       <= eos_d;
      overrun_q   <= overrun_d;
    end
  end

  assign EOC       = eoc_q;
  assign EOS       = eos_q;
  assign PIX_IDX   = pix_idx_q;
  assign PIX_DATA  = pix_data_q;
  assign INT_CNT   = int_cnt_q;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = (state_q != S_IDLE);
  assign OVERRUN   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_s10077_sensor_emu.sv
// Bench for s10077_sensor_emu: a small-parameter instance (NPIX=4,
// START_DLY=2, PIX_CLKS=2, SENSOR_CLK = FPGA_CLK/16) and a default-parameter
// instance with its own faster sensor clock for the long frame.
module tb_s10077_sensor_emu;

  // ---------------- clock / reset ----------------
  logic fpga_clk = 1'b0;
  logic fpga_rst = 1'b1;
  always #5 fpga_clk = ~fpga_clk;

  logic        sensor_clk = 1'b0;
  logic        st = 1'b0;
  logic        eoc, eos, busy, overrun;
  logic [10:0] pix_idx;
  logic [11:0] pix_data;
  logic [23:0] int_cnt;
  logic [15:0] frame_cnt;
  logic [2:0]  dbg_state;

  logic        d_sclk = 1'b0;
  logic        d_st = 1'b0;
  logic        d_eoc, d_eos, d_busy, d_overrun;
  logic [10:0] d_pix_idx;
  logic [11:0] d_pix_data;
  logic [23:0] d_int_cnt;
  logic [15:0] d_frame_cnt;
  logic [2:0]  d_dbg_state;

  s10077_sensor_emu #(.NPIX(4), .START_DLY(2), .PIX_CLKS(2)) dut (
    .FPGA_CLK(fpga_clk), .FPGA_RST(fpga_rst), .SENSOR_CLK(sensor_clk), .ST(st),
    .EOC(eoc), .EOS(eos), .PIX_IDX(pix_idx), .PIX_DATA(pix_data),
    .INT_CNT(int_cnt), .FRAME_CNT(frame_cnt), .BUSY(busy), .OVERRUN(overrun),
    .dbg_state(dbg_state)
  );

  s10077_sensor_emu dut_def (
    .FPGA_CLK(fpga_clk), .FPGA_RST(fpga_rst), .SENSOR_CLK(d_sclk), .ST(d_st),
    .EOC(d_eoc), .EOS(d_eos), .PIX_IDX(d_pix_idx), .PIX_DATA(d_pix_data),
    .INT_CNT(d_int_cnt), .FRAME_CNT(d_frame_cnt), .BUSY(d_busy), .OVERRUN(d_overrun),
    .dbg_state(d_dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  int sclk_rises = 0;

  // One SENSOR_CLK period = 16 FPGA_CLK; ST is only changed while it is low
  task automatic sclk_cycle();
    sensor_clk = 1'b1;
    sclk_rises++;
    repeat (8) @(negedge fpga_clk);
    sensor_clk = 1'b0;
    repeat (8) @(negedge fpga_clk);
  endtask

  task automatic d_cycle();
    d_sclk = 1'b1;
    repeat (2) @(negedge fpga_clk);
    d_sclk = 1'b0;
    repeat (2) @(negedge fpga_clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [11:0] exp_q[$];
  bit mon_en = 1'b0;
  int eoc_cnt = 0, eos_cnt = 0, both_hi = 0, spacing_err = 0;
  int first_eoc_rise = 0, last_eoc_rise = 0;
  logic eoc_prev = 1'b0, eos_prev = 1'b0;

  always @(negedge fpga_clk) begin
    if (eoc && !eoc_prev) begin
      eoc_cnt++;
      if (eoc_cnt == 1) first_eoc_rise = sclk_rises;
      else if (sclk_rises - last_eoc_rise != 2) spacing_err++;
      last_eoc_rise = sclk_rises;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL eoc_unexpected: got pix_data %0d expected no EOC", pix_data);
        end else begin
          check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        end
      end
    end
    if (eos && !eos_prev) eos_cnt++;
    if (eoc && eos) both_hi++;
    eoc_prev = eoc;
    eos_prev = eos;
  end

  int d_eoc_cnt = 0, d_eos_cnt = 0, d_eoc_at_eos = 0;
  logic [11:0] d_last_data = '0;
  logic d_eoc_prev = 1'b0, d_eos_prev = 1'b0;

  always @(negedge fpga_clk) begin
    if (d_eoc && !d_eoc_prev) begin
      d_eoc_cnt++;
      d_last_data = d_pix_data;
    end
    if (d_eos && !d_eos_prev) begin
      d_eos_cnt++;
      d_eoc_at_eos = d_eoc_cnt;
    end
    d_eoc_prev = d_eoc;
    d_eos_prev = d_eos;
  end

  task automatic clear_mon();
    eoc_cnt = 0; eos_cnt = 0; both_hi = 0; spacing_err = 0;
    first_eoc_rise = 0; last_eoc_rise = 0;
    exp_q.delete();
  endtask

  // ---------------- frame vectors ----------------
  typedef struct {
    int st_rises;     // SENSOR_CLK rises with ST high
    bit pulse_read;   // pulse ST for one period during READ
    int exp_int;
    int exp_fc;       // FRAME_CNT after the frame
    int exp_base;     // PIX_DATA of pixel 0
    bit exp_ovr;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    int low_rise;
    bit pulsed;
    bit done;
    clear_mon();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(12'((v.exp_base + i) % 4096));
    st = 1'b1;
    repeat (v.st_rises) sclk_cycle();
    st = 1'b0;
    low_rise = sclk_rises + 1;
    pulsed = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      sclk_cycle();
      if (v.pulse_read && !pulsed && dbg_state == 3'd3) begin
        st = 1'b1;
        sclk_cycle();
        st = 1'b0;
        pulsed = 1'b1;
      end
      if (!busy) done = 1'b1;
    end
    check("frame_done", 32'(done), 32'd1);
    check("int_cnt", 32'(int_cnt), 32'(v.exp_int));
    check("frame_cnt", 32'(frame_cnt), 32'(v.exp_fc));
    check("eoc_count", 32'(eoc_cnt), 32'd4);
    check("eos_count", 32'(eos_cnt), 32'd1);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);
    check("first_eoc_delay", 32'(first_eoc_rise - low_rise), 32'd2);
    check("eoc_spacing_err", 32'(spacing_err), 32'd0);
    check("eoc_eos_overlap", 32'(both_hi), 32'd0);
    check("overrun", 32'(overrun), 32'(v.exp_ovr));
    check("busy_end", 32'(busy), 32'd0);
    check("eoc_eos_end", {30'd0, eoc, eos}, 32'd0);
    mon_en = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit reached;
    bit done;
    vec_t v_after_rst;

    vecs[0] = '{st_rises: 10, pulse_read: 1'b0, exp_int: 10, exp_fc: 1, exp_base: 0, exp_ovr: 1'b0};
    vecs[1] = '{st_rises: 10, pulse_read: 1'b0, exp_int: 10, exp_fc: 2, exp_base: 1, exp_ovr: 1'b0};
    vecs[2] = '{st_rises: 3,  pulse_read: 1'b0, exp_int: 3,  exp_fc: 3, exp_base: 2, exp_ovr: 1'b0};
    vecs[3] = '{st_rises: 1,  pulse_read: 1'b1, exp_int: 1,  exp_fc: 4, exp_base: 3, exp_ovr: 1'b1};

    // Reset state
    repeat (3) @(negedge fpga_clk);
    check("rst_eoc_eos", {30'd0, eoc, eos}, 32'd0);
    check("rst_pix_idx", 32'(pix_idx), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_int_cnt", 32'(int_cnt), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy_ovr", {30'd0, busy, overrun}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    fpga_rst = 1'b0;
    repeat (4) @(negedge fpga_clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Reset pulse mid-READ: everything clears at once, no EOS follows
    clear_mon();
    st = 1'b1;
    repeat (4) sclk_cycle();
    st = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 10 && !reached; k++) begin
      sclk_cycle();
      if (dbg_state == 3'd3) reached = 1'b1;
    end
    check("reached_read", 32'(reached), 32'd1);
    @(negedge fpga_clk);
    #2 fpga_rst = 1'b1;
    #1;
    check("mid_rst_eoc_eos", {30'd0, eoc, eos}, 32'd0);
    check("mid_rst_pix_idx", 32'(pix_idx), 32'd0);
    check("mid_rst_pix_data", 32'(pix_data), 32'd0);
    check("mid_rst_int_cnt", 32'(int_cnt), 32'd0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge fpga_clk);
    fpga_rst = 1'b0;
    repeat (3) sclk_cycle();
    check("post_rst_eos", 32'(eos_cnt), 32'd0);
    check("post_rst_state", 32'(dbg_state), 32'd0);
    v_after_rst = '{st_rises: 5, pulse_read: 1'b0, exp_int: 5, exp_fc: 1, exp_base: 0, exp_ovr: 1'b0};
    run_vec(v_after_rst);

    // SENSOR_CLK stopped just after pixel 1's EOC rises: everything holds
    clear_mon();
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(12'(1 + i));
    st = 1'b1;
    repeat (2) sclk_cycle();
    st = 1'b0;
    repeat (5) sclk_cycle();
    repeat (200) @(negedge fpga_clk);
    check("stall_pix_idx", 32'(pix_idx), 32'd1);
    check("stall_eoc", 32'(eoc), 32'd1);
    check("stall_eos", 32'(eos), 32'd0);
    check("stall_pix_data", 32'(pix_data), 32'd2);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_eoc_count", 32'(eoc_cnt), 32'd2);
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      sclk_cycle();
      if (!busy) done = 1'b1;
    end
    check("stall_done", 32'(done), 32'd1);
    check("stall_eoc_total", 32'(eoc_cnt), 32'd4);
    check("stall_eos_total", 32'(eos_cnt), 32'd1);
    check("stall_frame_cnt", 32'(frame_cnt), 32'd2);
    check("stall_int_cnt", 32'(int_cnt), 32'd2);
    check("stall_exp_q_left", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    // Default parameters: long integration, full 1024-pixel readout
    d_st = 1'b1;
    repeat (6000) d_cycle();
    d_st = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 5000 && !done; k++) begin
      d_cycle();
      if (!d_busy) done = 1'b1;
    end
    check("def_done", 32'(done), 32'd1);
    check("def_int_cnt", 32'(d_int_cnt), 32'd6000);
    check("def_eoc_count", 32'(d_eoc_cnt), 32'd1024);
    check("def_eos_count", 32'(d_eos_cnt), 32'd1);
    check("def_eoc_before_eos", 32'(d_eoc_at_eos), 32'd1024);
    check("def_last_data", 32'(d_last_data), 32'd1023);
    check("def_frame_cnt", 32'(d_frame_cnt), 32'd1);
    check("def_overrun", 32'(d_overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

endmodule
